// File: rtl/map_loader.sv
// Level map consumer: fetches a map from the registered map ROM into a shadow
// register, answers single-cycle tile queries, and counts walls after each load.
module map_loader #(
  parameter int MAP_ROWS = 20,
  parameter int MAP_COLS = 30,
  parameter int LEVEL_W  = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_req,
  input  logic [LEVEL_W-1:0]           load_level,
  output logic                         load_busy,
  output logic                         map_valid,
  output logic                         count_valid,
  output logic [9:0]                   wall_count,
  output logic [LEVEL_W-1:0]           rom_level,
  input  logic [MAP_ROWS*MAP_COLS-1:0] rom_map,
  input  logic                         query_valid,
  input  logic [4:0]                   query_row,
  input  logic [4:0]                   query_col,
  output logic                         resp_valid,
  output logic                         resp_wall,
  output logic                         resp_oob
);

  localparam int MAP_BITS = MAP_ROWS * MAP_COLS;
  localparam logic [4:0] ROW_LIM = 5'(MAP_ROWS);
  localparam logic [4:0] COL_LIM = 5'(MAP_COLS);
  localparam logic [9:0] LAST_IDX = 10'(MAP_BITS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SCAN, READY} state_t;

  state_t               state_reg, state_next;
  logic [MAP_BITS-1:0]  shadow_reg;
  logic [LEVEL_W-1:0]   rom_level_reg;
  logic                 map_valid_reg;
  logic                 load_busy_reg;
  logic                 count_valid_reg;
  logic [9:0]           wall_count_reg;
  logic [9:0]           scan_idx_reg;
  logic                 resp_valid_reg;
  logic                 resp_wall_reg;
  logic                 resp_oob_reg;

  logic                 load_accept;
  logic                 scan_last;
  logic                 query_oob;
  logic                 tile_wall;
  logic [MAP_COLS-1:0]  map_row [MAP_ROWS];

  assign load_accept = load_req && (state_reg == IDLE || state_reg == READY);
  assign scan_last   = (scan_idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, READY: if (load_req) state_next = WAIT;
      WAIT:        state_next = CAPTURE;
      CAPTURE:     state_next = SCAN;
      SCAN:        if (scan_last) state_next = READY;
      default:     state_next = IDLE;
    endcase
  end

  // Load/scan datapath; the ROM output is only trusted in CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_level_reg   <= '0;
      shadow_reg      <= '0;
      map_valid_reg   <= 1'b0;
      load_busy_reg   <= 1'b0;
      count_valid_reg <= 1'b0;
      wall_count_reg  <= '0;
      scan_idx_reg    <= '0;
    end else begin
      if (load_accept) begin
        rom_level_reg   <= load_level;
        map_valid_reg   <= 1'b0;
        count_valid_reg <= 1'b0;
        load_busy_reg   <= 1'b1;
      end
      if (state_reg == CAPTURE) begin
        shadow_reg     <= rom_map;
        map_valid_reg  <= 1'b1;
        scan_idx_reg   <= '0;
        wall_count_reg <= '0;
      end
      if (state_reg == SCAN) begin
        wall_count_reg <= wall_count_reg + 10'(shadow_reg[scan_idx_reg]);
        scan_idx_reg   <= scan_idx_reg + 10'd1;
        if (scan_last) begin
          count_valid_reg <= 1'b1;
          load_busy_reg   <= 1'b0;
        end
      end
    end
  end

  // Row view of the shadow map so a query needs no multiply
  genvar gi;
  generate
    for (gi = 0; gi < MAP_ROWS; gi++) begin : g_row
      assign map_row[gi] = shadow_reg[gi*MAP_COLS +: MAP_COLS];
    end
  endgenerate

  always_comb begin
    query_oob = (query_row >= ROW_LIM) || (query_col >= COL_LIM);
    tile_wall = 1'b1;
    if (!query_oob && map_valid_reg) tile_wall = map_row[query_row][query_col];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg <= 1'b0;
      resp_wall_reg  <= 1'b0;
      resp_oob_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= query_valid;
      if (query_valid) begin
        resp_wall_reg <= tile_wall;
        resp_oob_reg  <= query_oob;
      end
    end
  end

  assign rom_level   = rom_level_reg;
  assign map_valid   = map_valid_reg;
  assign load_busy   = load_busy_reg;
  assign count_valid = count_valid_reg;
  assign wall_count  = wall_count_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_wall   = resp_wall_reg;
  assign resp_oob    = resp_oob_reg;

endmodule

// File: tb/tb_map_loader.sv
// Bench for map_loader: registered ROM model, table-driven tile queries checked
// through a response scoreboard, plus load/abort sequences.
module tb_map_loader;

  logic         clk;
  logic         rst_n;
  logic         load_req;
  logic [9:0]   load_level;
  logic         load_busy;
  logic         map_valid;
  logic         count_valid;
  logic [9:0]   wall_count;
  logic [9:0]   rom_level;
  logic [599:0] rom_map;
  logic         query_valid;
  logic [4:0]   query_row;
  logic [4:0]   query_col;
  logic         resp_valid;
  logic         resp_wall;
  logic         resp_oob;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en;
  logic qv_d;
  logic [1:0] exp_q [$];

  typedef struct {
    logic [4:0] row;
    logic [4:0] col;
    logic       wall;
    logic       oob;
  } qvec_t;
  qvec_t qtab [8];

  map_loader #(.MAP_ROWS(20), .MAP_COLS(30), .LEVEL_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_req(load_req), .load_level(load_level),
    .load_busy(load_busy), .map_valid(map_valid),
    .count_valid(count_valid), .wall_count(wall_count),
    .rom_level(rom_level), .rom_map(rom_map),
    .query_valid(query_valid), .query_row(query_row), .query_col(query_col),
    .resp_valid(resp_valid), .resp_wall(resp_wall), .resp_oob(resp_oob)
  );

  always #5 clk = ~clk;

  function automatic logic [599:0] rom_image(input logic [9:0] lvl);
    logic [599:0] m;
    m = '0;
    case (lvl)
      10'd3: begin m[0] = 1'b1; m[31] = 1'b1; m[599] = 1'b1; end
      10'd5: begin m[10] = 1'b1; m[200] = 1'b1; end
      10'd7: m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // ROM with one cycle registered latency
  always @(posedge clk) rom_map <= rom_image(rom_level);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) qv_d <= 1'b0;
    else        qv_d <= query_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rom_level"},   32'(rom_level),   0);
    check({tag, "_map_valid"},   32'(map_valid),   0);
    check({tag, "_load_busy"},   32'(load_busy),   0);
    check({tag, "_count_valid"}, 32'(count_valid), 0);
    check({tag, "_wall_count"},  32'(wall_count),  0);
    check({tag, "_resp_valid"},  32'(resp_valid),  0);
    check({tag, "_resp_wall"},   32'(resp_wall),   0);
    check({tag, "_resp_oob"},    32'(resp_oob),    0);
  endtask

  task automatic send_query(input logic [4:0] r, input logic [4:0] c, input logic w, input logic o);
    query_valid = 1'b1;
    query_row   = r;
    query_col   = c;
    exp_q.push_back({w, o});
  endtask

  // Response monitor: one response per query, one cycle later
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("resp_valid", 32'(resp_valid), 32'(qv_d));
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_extra: got response wall=%0d oob=%0d, expected none", resp_wall, resp_oob);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("resp_wall", 32'(resp_wall), 32'(e[1]));
          check("resp_oob",  32'(resp_oob),  32'(e[0]));
          $display("query resp wall=%0d oob=%0d expected %0d/%0d", resp_wall, resp_oob, e[1], e[0]);
        end
      end
    end
  end

  // Load lvl; optionally inject an ignored request, query in WAIT, or abort at scan cycle
  task automatic do_load(input logic [9:0] lvl, input int exp_cnt, input bit inject,
                         input bit wq, input int abort_at);
    bit done;
    bit aborted;
    done = 0;
    aborted = 0;
    @(negedge clk);
    load_req = 1'b1;
    load_level = lvl;
    @(posedge clk); #1;
    load_req = 1'b0;
    check("rom_level_T",   32'(rom_level),   32'(lvl));
    check("map_valid_T",   32'(map_valid),   0);
    check("load_busy_T",   32'(load_busy),   1);
    check("count_valid_T", 32'(count_valid), 0);
    if (wq) send_query(5'd5, 5'd5, 1'b1, 1'b0);
    for (int n = 1; n <= 1000 && !done && !aborted; n++) begin
      @(posedge clk); #1;
      if (wq && n == 1) query_valid = 1'b0;
      if (n == 1) check("map_valid_wait", 32'(map_valid), 0);
      if (n == 2) begin
        check("map_valid_cap", 32'(map_valid), 1);
        check("wall_count_cap", 32'(wall_count), 0);
      end
      if (inject && n == 100) begin load_req = 1'b1; load_level = 10'd5; end
      if (inject && n == 101) load_req = 1'b0;
      if (abort_at != 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        aborted = 1;
      end else if (count_valid) begin
        done = 1;
        check("scan_len",   32'(n),          602);
        check("wall_count", 32'(wall_count), 32'(exp_cnt));
        check("load_busy_done", 32'(load_busy), 0);
        check("map_valid_done", 32'(map_valid), 1);
        check("rom_level_done", 32'(rom_level), 32'(lvl));
        $display("load level %0d: wall_count=%0d after %0d cycles", lvl, wall_count, n);
      end
    end
    if (aborted) begin
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end else if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: count_valid never rose for level %0d", lvl);
    end
  endtask

  initial begin
    clk = 0; rst_n = 1; load_req = 0; load_level = 0;
    query_valid = 0; query_row = 0; query_col = 0; mon_en = 0;

    qtab[0] = '{5'd0,  5'd0,  1'b1, 1'b0};
    qtab[1] = '{5'd1,  5'd1,  1'b1, 1'b0};
    qtab[2] = '{5'd19, 5'd29, 1'b1, 1'b0};
    qtab[3] = '{5'd0,  5'd1,  1'b0, 1'b0};
    qtab[4] = '{5'd20, 5'd0,  1'b1, 1'b1};
    qtab[5] = '{5'd0,  5'd30, 1'b1, 1'b1};
    qtab[6] = '{5'd5,  5'd5,  1'b0, 1'b0};
    qtab[7] = '{5'd1,  5'd0,  1'b0, 1'b0};

    // Asynchronous reset asserted mid-cycle
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Idle query is fail-safe blocked
    @(negedge clk);
    send_query(5'd0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    query_valid = 1'b0;

    do_load(10'd3, 3, 0, 0, 0);

    // Back-to-back table queries against level 3
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send_query(qtab[i].row, qtab[i].col, qtab[i].wall, qtab[i].oob);
      @(negedge clk);
    end
    query_valid = 1'b0;
    @(negedge clk);

    // Request during SCAN is ignored
    do_load(10'd3, 3, 1, 0, 0);

    // Reload from READY with all-ones map; query during WAIT is blocked
    do_load(10'd7, 600, 0, 1, 0);
    @(negedge clk);
    send_query(5'd0, 5'd1, 1'b1, 1'b0);
    @(negedge clk);
    send_query(5'd5, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    query_valid = 1'b0;

    // Reset at scan index 300, then a clean reload
    do_load(10'd3, 3, 0, 0, 302);
    do_load(10'd3, 3, 0, 0, 0);
    @(negedge clk);
    send_query(5'd19, 5'd29, 1'b1, 1'b0);
    @(negedge clk);
    send_query(5'd5, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    query_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
